count_updn: RTL and testbench
=============================

// Module: count_updn
// PURPOSE
//  Parametrised modulo up/down counter; general-purpose successor to the fixed 4-bit free-running counter.
//  Adds programmable width and modulus, wrap or saturate mode, enable prescaler, direction, sync clear/load,
//  a registered carry/borrow pulse and a sticky overflow flag. Used for timers, address generators, event counts.
// PARAMETERS
//  WIDTH  4   counter width in bits (>=1)
//  MAX    15  terminal value; count range 0..MAX; MAX <= 2**WIDTH-1 (elaboration error otherwise)
//  SAT    0   0 = wrap at boundaries, 1 = saturate (hold) at boundaries
//  DIV    1   prescaler: count steps once per DIV qualified enable cycles (>=1; 1 = every enabled cycle)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous reset, active low
//  clr       in   1      synchronous clear to 0
//  load      in   1      synchronous load of load_val
//  load_val  in   WIDTH  load value
//  en        in   1      count enable
//  up        in   1      direction: 1 = increment, 0 = decrement
//  ovf_clr   in   1      clears sticky ovf
//  count     out  WIDTH  current count (registered)
//  carry     out  1      one-cycle pulse: boundary event occurred at previous edge
//  ovf       out  1      sticky boundary-event flag
// BEHAVIOUR
//  Reset (rst=0, async): count=0, carry=0, ovf=0, prescaler=0. All outputs registered; no comb paths in->out.
//  Priority per edge: clr > load > en. clr/load also zero the prescaler; neither raises carry/ovf.
//  load: count <= (load_val > MAX) ? MAX : load_val (clamped).
//  Prescaler: on en=1 (no clr/load), psc==DIV-1 -> psc<=0 and a step occurs; else psc<=psc+1, no step.
//   en=0 holds psc and count. DIV=1: every enabled edge steps.
//  Step up: count<MAX -> count+1; count==MAX -> boundary event: wrap 0 (SAT=0) / hold MAX (SAT=1).
//  Step down: count>0 -> count-1; count==0 -> boundary event: wrap MAX (SAT=0) / hold 0 (SAT=1).
//  Values above MAX are unreachable (load clamps); arithmetic done in WIDTH bits, no reliance on natural overflow.
//  carry: 1 for exactly the cycle after an edge with a boundary event; 0 otherwise. In SAT mode each
//   attempted step past the boundary is an event (carry repeats while held at boundary with steps).
//  ovf: set on boundary event; cleared by ovf_clr; set wins if both at same edge. clr does not clear ovf.
//  Direction change mid-prescale: takes effect on the next step; psc is not reset.
//  Reset mid-operation: immediate async return to reset values; counting resumes from 0 after release.
// TESTING
//  1 Defaults, en=1 up=1 20 cycles -> count 0..15,0..3; carry high the cycle count shows 0 after 15; ovf=1.
//  2 MAX=9 SAT=0, up=0 from reset, en=1 -> count 9,8..0,9; carry pulse after each 0->9 wrap.
//  3 MAX=9 SAT=1, load 7, up=1, en=1 5 cycles -> 8,9,9,9,9; carry on each held step; ovf_clr+event same edge -> ovf stays 1.
//  4 DIV=3, en=1 up=1 -> count steps every 3rd edge; en low 2 cycles mid-prescale -> phase preserved.
//  5 load_val=12 with MAX=9 -> count=9; clr+load+en same edge -> count=0, carry=0, psc=0.
//  6 Assert rst mid-count (async, between edges) -> count/carry/ovf 0 immediately; release -> count 1 after first enabled step.

Source files
------------

// File: rtl/count_updn.sv
// count_updn: parametrised modulo up/down counter.
//   The count runs over 0..MAX. At a boundary it either wraps (SAT=0) or
//   holds (SAT=1). A prescaler lets the count step once every DIV enabled
//   cycles. clr and load are synchronous, and clr takes priority over load.
//   carry is a registered one-cycle pulse. ovf is a sticky flag.
// Ports:
//   clk       in  rising-edge clock
//   rst       in  asynchronous reset, active low
//   clr       in  synchronous clear of count and prescaler
//   load      in  synchronous load of load_val (clamped to MAX)
//   load_val  in  [WIDTH-1:0] load value
//   en        in  count enable (qualifies the prescaler)
//   up        in  direction, 1 = increment, 0 = decrement
//   ovf_clr   in  clears the sticky ovf flag (a new event at the same edge wins)
//   count     out [WIDTH-1:0] current count
//   carry     out pulse in the cycle after an edge that had a boundary event
//   ovf       out sticky boundary-event flag
module count_updn #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MAX   = 15,
  parameter int unsigned SAT   = 0,
  parameter int unsigned DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             ovf
);

  // Prescaler width covers 0..DIV-1. It is kept at 1 bit when DIV is 1.
  localparam int unsigned PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX);
  localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(DIV - 1);
  localparam bit               SAT_MODE = (SAT != 0);

  // Parameter legality checks, done at elaboration time.
  if (WIDTH < 1) begin : g_bad_width
    $error("count_updn: WIDTH must be >= 1");
  end
  if (DIV < 1) begin : g_bad_div
    $error("count_updn: DIV must be >= 1");
  end
  if (64'(MAX) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("count_updn: MAX exceeds 2**WIDTH-1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             bnd_evt;

  // Next-state logic. The priority order is clr, then load, then the enabled prescaler and step.
  always_comb begin
    count_d = count_q;
    psc_d   = psc_q;
    carry_d = 1'b0;
    ovf_d   = ovf_q;
    step    = 1'b0;
    bnd_evt = 1'b0;

    if (ovf_clr) begin
      ovf_d = 1'b0;
    end

    if (clr) begin
      count_d = '0;
      psc_d   = '0;
    end else if (load) begin
      // A one-bit-wider compare makes the clamp valid even when MAX is all ones.
      if ({1'b0, load_val} > (WIDTH + 1)'(MAX)) begin
        count_d = MAX_V;
      end else begin
        count_d = load_val;
      end
      psc_d = '0;
    end else if (en) begin
      if (psc_q == PSC_LAST) begin
        psc_d = '0;
        step  = 1'b1;
      end else begin
        psc_d = psc_q + PSC_W'(1);
      end

      // Check for the boundary before doing any arithmetic, so no natural overflow is used.
      if (step) begin
        if (up) begin
          if (count_q == MAX_V) begin
            bnd_evt = 1'b1;
            count_d = SAT_MODE ? MAX_V : '0;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            bnd_evt = 1'b1;
            count_d = SAT_MODE ? '0 : MAX_V;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end

    // A boundary event sets the flags. This overrides ovf_clr at the same edge.
    if (bnd_evt) begin
      carry_d = 1'b1;
      ovf_d   = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      psc_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      psc_q   <= psc_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign carry = carry_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_count_updn.sv
// Testbench for count_updn. Four instances with different parameter sets
// share one stimulus stream. An arithmetic reference model checks every
// instance, and explicit expectations cover the directed corner cases.
module tb_count_updn;

  localparam int NI = 4;
  localparam int P_MAX [NI] = '{15, 9, 9, 15};
  localparam int P_SAT [NI] = '{0, 0, 1, 0};
  localparam int P_DIV [NI] = '{1, 1, 1, 3};

  logic       clk = 1'b0;
  logic       rst, clr, load, en, up, ovf_clr;
  logic [3:0] load_val;
  logic [3:0] cnt_o   [NI];
  logic       carry_o [NI];
  logic       ovf_o   [NI];

  always #5 clk = ~clk;

  count_updn #(.WIDTH(4), .MAX(15), .SAT(0), .DIV(1)) u0 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up(up), .ovf_clr(ovf_clr), .count(cnt_o[0]), .carry(carry_o[0]), .ovf(ovf_o[0]));
  count_updn #(.WIDTH(4), .MAX(9), .SAT(0), .DIV(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up(up), .ovf_clr(ovf_clr), .count(cnt_o[1]), .carry(carry_o[1]), .ovf(ovf_o[1]));
  count_updn #(.WIDTH(4), .MAX(9), .SAT(1), .DIV(1)) u2 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up(up), .ovf_clr(ovf_clr), .count(cnt_o[2]), .carry(carry_o[2]), .ovf(ovf_o[2]));
  count_updn #(.WIDTH(4), .MAX(15), .SAT(0), .DIV(3)) u3 (
    .clk(clk), .rst(rst), .clr(clr), .load(load), .load_val(load_val), .en(en),
    .up(up), .ovf_clr(ovf_clr), .count(cnt_o[3]), .carry(carry_o[3]), .ovf(ovf_o[3]));

  int total = 0;
  int bad   = 0;

  // Reference model state, kept as plain integers.
  int m_cnt [NI];
  int m_psc [NI];
  int m_car [NI];
  int m_ovf [NI];

  typedef struct {
    bit clr; bit load; int lv; bit en; bit up; bit oc;
    int cnt; int car; int ovf;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_cnt[i] = 0; m_psc[i] = 0; m_car[i] = 0; m_ovf[i] = 0;
    end
  endtask

  // Apply the behaviour rules directly: the count is an integer in 0..MAX,
  // and an out-of-range target is a boundary event.
  task automatic model_edge();
    int tgt;
    int evt;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      evt = 0;
      if (clr) begin
        m_cnt[i] = 0; m_psc[i] = 0;
      end else if (load) begin
        m_cnt[i] = (int'(load_val) > P_MAX[i]) ? P_MAX[i] : int'(load_val);
        m_psc[i] = 0;
      end else if (en) begin
        m_psc[i] = m_psc[i] + 1;
        if (m_psc[i] == P_DIV[i]) begin
          m_psc[i] = 0;
          tgt = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
          if (tgt < 0 || tgt > P_MAX[i]) begin
            evt = 1;
            if (P_SAT[i] != 0) m_cnt[i] = up ? P_MAX[i] : 0;
            else               m_cnt[i] = up ? 0 : P_MAX[i];
          end else begin
            m_cnt[i] = tgt;
          end
        end
      end
      m_car[i] = evt;
      if (evt != 0)   m_ovf[i] = 1;
      else if (ovf_clr) m_ovf[i] = 0;
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s u%0d count", tag, i), int'(cnt_o[i]), m_cnt[i]);
      check($sformatf("%s u%0d carry", tag, i), int'(carry_o[i]), m_car[i]);
      check($sformatf("%s u%0d ovf", tag, i), int'(ovf_o[i]), m_ovf[i]);
    end
  endtask

  // One clock edge: update the model at the edge, then sample 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    clr = 0; load = 0; load_val = 4'd0; en = 0; up = 0; ovf_clr = 0;
  endtask

  // Asynchronous reset pulse between clock edges; it must take effect before the next edge.
  task automatic async_reset(input string tag);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_model(tag);
    #1 rst = 1'b1;
  endtask

  vec_t vecs [12];

  initial begin
    // Table for u2 (MAX=9, SAT=1), starting from the reset state.
    vecs[0]  = '{clr:0, load:1, lv:7,  en:0, up:0, oc:0, cnt:7, car:0, ovf:0};
    vecs[1]  = '{clr:0, load:0, lv:0,  en:1, up:1, oc:0, cnt:8, car:0, ovf:0};
    vecs[2]  = '{clr:0, load:0, lv:0,  en:1, up:1, oc:0, cnt:9, car:0, ovf:0};
    vecs[3]  = '{clr:0, load:0, lv:0,  en:1, up:1, oc:0, cnt:9, car:1, ovf:1};
    vecs[4]  = '{clr:0, load:0, lv:0,  en:1, up:1, oc:0, cnt:9, car:1, ovf:1};
    vecs[5]  = '{clr:0, load:0, lv:0,  en:1, up:1, oc:1, cnt:9, car:1, ovf:1};
    vecs[6]  = '{clr:0, load:0, lv:0,  en:0, up:1, oc:1, cnt:9, car:0, ovf:0};
    vecs[7]  = '{clr:0, load:1, lv:12, en:0, up:0, oc:0, cnt:9, car:0, ovf:0};
    vecs[8]  = '{clr:1, load:1, lv:5,  en:1, up:1, oc:0, cnt:0, car:0, ovf:0};
    vecs[9]  = '{clr:0, load:0, lv:0,  en:1, up:0, oc:0, cnt:0, car:1, ovf:1};
    vecs[10] = '{clr:1, load:0, lv:0,  en:0, up:0, oc:0, cnt:0, car:0, ovf:1};
    vecs[11] = '{clr:0, load:0, lv:0,  en:1, up:1, oc:0, cnt:1, car:0, ovf:1};

    idle_inputs();
    rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_model("reset");
    check("reset u0 count", int'(cnt_o[0]), 0);
    rst = 1'b1;

    // Default instance counts up and wraps after 15.
    async_reset("t1 rst");
    en = 1; up = 1;
    for (int k = 1; k <= 20; k++) begin
      tick("t1");
      check("t1 u0 count", int'(cnt_o[0]), k % 16);
      check("t1 u0 carry", int'(carry_o[0]), (k == 16) ? 1 : 0);
      check("t1 u0 ovf", int'(ovf_o[0]), (k >= 16) ? 1 : 0);
    end

    // MAX=9 wrap instance counts down from reset.
    idle_inputs();
    async_reset("t2 rst");
    en = 1; up = 0;
    for (int k = 1; k <= 22; k++) begin
      tick("t2");
      check("t2 u1 count", int'(cnt_o[1]), (10 - (k % 10)) % 10);
      check("t2 u1 carry", int'(carry_o[1]), (k % 10 == 1) ? 1 : 0);
    end

    // Table: saturating behaviour, load clamp, and clr/load/en priority.
    idle_inputs();
    async_reset("t3 rst");
    for (int v = 0; v < 12; v++) begin
      clr = vecs[v].clr; load = vecs[v].load; load_val = 4'(vecs[v].lv);
      en = vecs[v].en; up = vecs[v].up; ovf_clr = vecs[v].oc;
      tick($sformatf("t3 v%0d", v));
      check($sformatf("t3 v%0d u2 count", v), int'(cnt_o[2]), vecs[v].cnt);
      check($sformatf("t3 v%0d u2 carry", v), int'(carry_o[2]), vecs[v].car);
      check($sformatf("t3 v%0d u2 ovf", v), int'(ovf_o[2]), vecs[v].ovf);
    end

    // DIV=3 prescaler, with en dropped for 2 cycles mid-prescale.
    idle_inputs();
    async_reset("t4 rst");
    en = 1; up = 1;
    for (int k = 1; k <= 4; k++) begin
      tick("t4a");
      check("t4a u3 count", int'(cnt_o[3]), k / 3);
    end
    en = 0;
    for (int k = 0; k < 2; k++) begin
      tick("t4b");
      check("t4b u3 count", int'(cnt_o[3]), 1);
    end
    en = 1;
    begin
      int exp4 [5] = '{1, 2, 2, 2, 3};
      for (int k = 0; k < 5; k++) begin
        tick("t4c");
        check("t4c u3 count", int'(cnt_o[3]), exp4[k]);
      end
    end

    // Asynchronous reset mid-count, then resume counting from 0.
    idle_inputs();
    async_reset("t6 rst0");
    en = 1; up = 1;
    repeat (5) tick("t6a");
    check("t6 u0 pre count", int'(cnt_o[0]), 5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_model("t6 async");
    check("t6 u0 count immed", int'(cnt_o[0]), 0);
    check("t6 u0 ovf immed", int'(ovf_o[0]), 0);
    tick("t6 held");
    #1 rst = 1'b1;
    tick("t6 resume");
    check("t6 u0 count resume", int'(cnt_o[0]), 1);

    // Randomised traffic checked against the model.
    idle_inputs();
    async_reset("rnd rst");
    for (int n = 0; n < 3000; n++) begin
      clr      = ($urandom % 100) < 3;
      load     = ($urandom % 100) < 6;
      load_val = 4'($urandom % 16);
      en       = ($urandom % 100) < 75;
      up       = ($urandom % 100) < ((n / 500) % 2 == 0 ? 70 : 30);
      ovf_clr  = ($urandom % 100) < 5;
      if ($urandom % 200 == 0) async_reset("rnd async");
      tick("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
